// File: rtl/bpu_pkg.sv
// Shared encodings for the branch predictor: Decode branch/jump codes,
// forwarding selects and the 2-bit saturating counter policy.
package bpu_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_NONE = 3'b010,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_e;

  typedef enum logic {
    JT_JALR = 1'b0,
    JT_JAL  = 1'b1
  } jump_type_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_E    = 2'b01,
    FWD_M    = 2'b10,
    FWD_W    = 2'b11
  } fwd_e;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;
  localparam logic [1:0] CTR_JUMP  = 2'b11;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bpu_table.sv
// Direct-mapped BTB storage: valid/tag/target/counter arrays with two
// asynchronous read ports (Fetch, Decode) and one synchronous write port.
module bpu_table
  import bpu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_f,
  output logic             rd_valid_f,
  output logic [TAG_W-1:0] rd_tag_f,
  output logic [XLEN-1:0]  rd_target_f,
  output logic [1:0]       rd_ctr_f,
  input  logic [IDX_W-1:0] rd_idx_d,
  output logic             rd_valid_d,
  output logic [TAG_W-1:0] rd_tag_d,
  output logic [XLEN-1:0]  rd_target_d,
  output logic [1:0]       rd_ctr_d,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_target,
  input  logic [1:0]       wr_ctr
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  assign rd_valid_f  = valid_q[rd_idx_f];
  assign rd_tag_f    = tag_q[rd_idx_f];
  assign rd_target_f = target_q[rd_idx_f];
  assign rd_ctr_f    = ctr_q[rd_idx_f];

  assign rd_valid_d  = valid_q[rd_idx_d];
  assign rd_tag_d    = tag_q[rd_idx_d];
  assign rd_target_d = target_q[rd_idx_d];
  assign rd_ctr_d    = ctr_q[rd_idx_d];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else if (we) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      ctr_q[wr_idx]    <= wr_ctr;
    end
  end

endmodule

// File: rtl/bpu_branch_predictor.sv
// Fetch-side BTB prediction plus Decode-side branch/jump resolution,
// misprediction redirect, BTB training and performance counters.
module bpu_branch_predictor
  import bpu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] PC_F,
  output logic            pred_taken_F,
  output logic [XLEN-1:0] pred_target_F,
  input  logic            valid_D,
  input  logic            stall_D,
  input  logic [XLEN-1:0] PC_D,
  input  logic [XLEN-1:0] rs1_D,
  input  logic [XLEN-1:0] rs2_D,
  input  logic [XLEN-1:0] imm_D,
  input  logic [XLEN-1:0] ALU_result_E,
  input  logic [XLEN-1:0] ALU_result_M,
  input  logic [XLEN-1:0] WB_data,
  input  logic [1:0]      forward_A_D,
  input  logic [1:0]      forward_B_D,
  input  logic [2:0]      branch,
  input  logic            jump,
  input  logic            jump_type,
  input  logic            pred_taken_D,
  input  logic [XLEN-1:0] pred_target_D,
  output logic            redirect_D,
  output logic [XLEN-1:0] redirect_PC_D,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [XLEN-1:0]  rs1f, rs2f, off, br_target, jalr_sum, jalr_target, target;
  logic             br_real, br_cond, taken, ctl, mispredict, update;
  logic [IDX_W-1:0] idx_f, idx_d;
  logic [TAG_W-1:0] tag_f, tag_d;
  logic             rd_valid_f, rd_valid_d, hit_f, hit_d;
  logic [TAG_W-1:0] rd_tag_f, rd_tag_d;
  logic [XLEN-1:0]  rd_target_f, rd_target_d;
  logic [1:0]       rd_ctr_f, rd_ctr_d;
  logic             we;
  logic [TAG_W-1:0] wr_tag;
  logic [XLEN-1:0]  wr_target;
  logic [1:0]       wr_ctr;

  always_comb begin
    case (forward_A_D)
      FWD_E:   rs1f = ALU_result_E;
      FWD_M:   rs1f = ALU_result_M;
      FWD_W:   rs1f = WB_data;
      default: rs1f = rs1_D;
    endcase
    case (forward_B_D)
      FWD_E:   rs2f = ALU_result_E;
      FWD_M:   rs2f = ALU_result_M;
      FWD_W:   rs2f = WB_data;
      default: rs2f = rs2_D;
    endcase
  end

  // PCs are word indices while imm_D is a byte offset.
  assign off         = $signed(imm_D) >>> 2;
  assign br_target   = PC_D + off;
  assign jalr_sum    = rs1f + imm_D;
  assign jalr_target = (jalr_sum & ~XLEN'(1)) >> 2;

  always_comb begin
    br_real = 1'b1;
    br_cond = 1'b0;
    case (branch)
      BR_BEQ:  br_cond = (rs1f == rs2f);
      BR_BNE:  br_cond = (rs1f != rs2f);
      BR_BLT:  br_cond = ($signed(rs1f) <  $signed(rs2f));
      BR_BGE:  br_cond = ($signed(rs1f) >= $signed(rs2f));
      BR_BLTU: br_cond = (rs1f <  rs2f);
      BR_BGEU: br_cond = (rs1f >= rs2f);
      default: br_real = 1'b0;
    endcase
  end

  assign taken  = jump | (br_real & br_cond);
  assign target = (jump && jump_type == JT_JALR) ? jalr_target : br_target;
  assign ctl    = valid_D & (jump | br_real);
  assign update = ctl & ~stall_D;

  // A non-control instruction predicted taken came from a stale alias.
  assign mispredict = ctl ? ((taken != pred_taken_D) | (taken & (target != pred_target_D)))
                          : pred_taken_D;
  assign redirect_D    = mispredict & ~stall_D;
  assign redirect_PC_D = (ctl & taken) ? target : PC_D + XLEN'(1);

  assign idx_f = PC_F[IDX_W-1:0];
  assign tag_f = PC_F[IDX_W+TAG_W-1:IDX_W];
  assign idx_d = PC_D[IDX_W-1:0];
  assign tag_d = PC_D[IDX_W+TAG_W-1:IDX_W];
  assign hit_f = rd_valid_f & (rd_tag_f == tag_f);
  assign hit_d = rd_valid_d & (rd_tag_d == tag_d);

  assign pred_taken_F  = hit_f & rd_ctr_f[1];
  assign pred_target_F = pred_taken_F ? rd_target_f : PC_F + XLEN'(1);

  always_comb begin
    we        = 1'b0;
    wr_tag    = tag_d;
    wr_target = rd_target_d;
    wr_ctr    = rd_ctr_d;
    if (update) begin
      if (jump) begin
        we        = 1'b1;
        wr_target = target;
        wr_ctr    = CTR_JUMP;
      end else if (hit_d) begin
        we     = 1'b1;
        wr_ctr = ctr_step(rd_ctr_d, taken);
        if (taken) wr_target = target;
      end else if (taken) begin
        we        = 1'b1;
        wr_target = target;
        wr_ctr    = CTR_ALLOC;
      end
    end
  end

  bpu_table #(
    .XLEN   (XLEN),
    .ENTRIES(ENTRIES),
    .TAG_W  (TAG_W)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_f   (idx_f),
    .rd_valid_f (rd_valid_f),
    .rd_tag_f   (rd_tag_f),
    .rd_target_f(rd_target_f),
    .rd_ctr_f   (rd_ctr_f),
    .rd_idx_d   (idx_d),
    .rd_valid_d (rd_valid_d),
    .rd_tag_d   (rd_tag_d),
    .rd_target_d(rd_target_d),
    .rd_ctr_d   (rd_ctr_d),
    .we         (we),
    .wr_idx     (idx_d),
    .wr_tag     (wr_tag),
    .wr_target  (wr_target),
    .wr_ctr     (wr_ctr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (update && branch_cnt != '1)      branch_cnt  <= branch_cnt + 32'd1;
      if (redirect_D && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_bpu_branch_predictor.sv
// Scenario bench for bpu_branch_predictor: expected redirect/prediction
// values are queued when stimulus is applied and compared on sampling.
module tb_bpu_branch_predictor;
  import bpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] PC_F = '0;
  logic        pred_taken_F;
  logic [31:0] pred_target_F;
  logic        valid_D, stall_D, jump, jump_type, pred_taken_D;
  logic [31:0] PC_D, rs1_D, rs2_D, imm_D, ALU_result_E, ALU_result_M, WB_data, pred_target_D;
  logic [1:0]  forward_A_D, forward_B_D;
  logic [2:0]  branch;
  logic        redirect_D;
  logic [31:0] redirect_PC_D, branch_cnt, mispred_cnt;

  bpu_branch_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .PC_F(PC_F), .pred_taken_F(pred_taken_F),
    .pred_target_F(pred_target_F), .valid_D(valid_D), .stall_D(stall_D),
    .PC_D(PC_D), .rs1_D(rs1_D), .rs2_D(rs2_D), .imm_D(imm_D),
    .ALU_result_E(ALU_result_E), .ALU_result_M(ALU_result_M), .WB_data(WB_data),
    .forward_A_D(forward_A_D), .forward_B_D(forward_B_D), .branch(branch),
    .jump(jump), .jump_type(jump_type), .pred_taken_D(pred_taken_D),
    .pred_target_D(pred_target_D), .redirect_D(redirect_D),
    .redirect_PC_D(redirect_PC_D), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        flag;
    logic [31:0] pc;
  } exp_t;

  exp_t        dec_q[$];
  exp_t        fet_q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_b = '0;
  logic [31:0] exp_m = '0;

  task automatic clr_dec();
    valid_D = 1'b0; stall_D = 1'b0; jump = 1'b0; jump_type = 1'b0;
    pred_taken_D = 1'b0; pred_target_D = '0; branch = BR_NONE;
    PC_D = '0; rs1_D = '0; rs2_D = '0; imm_D = '0;
    ALU_result_E = '0; ALU_result_M = '0; WB_data = '0;
    forward_A_D = FWD_NONE; forward_B_D = FWD_NONE;
  endtask

  task automatic step();
    @(posedge clk); #1;
    clr_dec();
  endtask

  task automatic dec_in(input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] im, input logic [2:0] br, input logic jmp,
                        input logic jt, input logic pt, input logic [31:0] ptgt);
    valid_D = 1'b1; PC_D = pc; rs1_D = r1; rs2_D = r2; imm_D = im; branch = br;
    jump = jmp; jump_type = jt; pred_taken_D = pt; pred_target_D = ptgt;
  endtask

  task automatic push_dec(input string n, input logic f, input logic [31:0] pc);
    exp_t x;
    x.name = n; x.flag = f; x.pc = pc;
    dec_q.push_back(x);
  endtask

  task automatic push_fet(input string n, input logic f, input logic [31:0] pc);
    exp_t x;
    x.name = n; x.flag = f; x.pc = pc;
    fet_q.push_back(x);
  endtask

  task automatic test_reset();
    clr_dec();
    rst_n = 1'b0; PC_F = 32'h10;
    push_fet("reset_fetch", 1'b0, 32'h11);
    #1;
    e = fet_q.pop_front(); checks++;
    if ({pred_taken_F, pred_target_F} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got taken=%b target=%h want %b %h", e.name, pred_taken_F, pred_target_F, e.flag, e.pc);
    end
    checks++;
    if ({branch_cnt, mispred_cnt} !== {exp_b, exp_m}) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d want %0d/%0d", branch_cnt, mispred_cnt, exp_b, exp_m);
    end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_beq();
    // Taken BEQ, predicted not taken: allocate with ctr=10.
    dec_in(32'h20, 32'd5, 32'd5, 32'hFFFF_FFF8, BR_BEQ, 1'b0, 1'b0, 1'b0, '0);
    push_dec("beq_taken", 1'b1, 32'h1E);
    #1;
    e = dec_q.pop_front(); checks++;
    if ({redirect_D, redirect_PC_D} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got redirect=%b pc=%h want %b %h", e.name, redirect_D, redirect_PC_D, e.flag, e.pc);
    end
    step(); exp_b++; exp_m++;
    PC_F = 32'h20;
    push_fet("beq_alloc_fetch", 1'b1, 32'h1E);
    #1;
    e = fet_q.pop_front(); checks++;
    if ({pred_taken_F, pred_target_F} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got taken=%b target=%h want %b %h", e.name, pred_taken_F, pred_target_F, e.flag, e.pc);
    end
    // Not taken, predicted taken: ctr 10 -> 01.
    dec_in(32'h20, 32'd5, 32'd6, 32'hFFFF_FFF8, BR_BEQ, 1'b0, 1'b0, 1'b1, 32'h1E);
    push_dec("beq_nt1", 1'b1, 32'h21);
    #1;
    e = dec_q.pop_front(); checks++;
    if ({redirect_D, redirect_PC_D} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got redirect=%b pc=%h want %b %h", e.name, redirect_D, redirect_PC_D, e.flag, e.pc);
    end
    step(); exp_b++; exp_m++;
    push_fet("beq_nt1_fetch", 1'b0, 32'h21);
    #1;
    e = fet_q.pop_front(); checks++;
    if ({pred_taken_F, pred_target_F} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got taken=%b target=%h want %b %h", e.name, pred_taken_F, pred_target_F, e.flag, e.pc);
    end
    // Not taken, predicted not taken: no redirect, ctr 01 -> 00.
    dec_in(32'h20, 32'd5, 32'd6, 32'hFFFF_FFF8, BR_BEQ, 1'b0, 1'b0, 1'b0, '0);
    push_dec("beq_nt2", 1'b0, 32'h21);
    #1;
    e = dec_q.pop_front(); checks++;
    if ({redirect_D, redirect_PC_D} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got redirect=%b pc=%h want %b %h", e.name, redirect_D, redirect_PC_D, e.flag, e.pc);
    end
    step(); exp_b++;
    push_fet("beq_nt2_fetch", 1'b0, 32'h21);
    #1;
    e = fet_q.pop_front(); checks++;
    if ({pred_taken_F, pred_target_F} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got taken=%b target=%h want %b %h", e.name, pred_taken_F, pred_target_F, e.flag, e.pc);
    end
    checks++;
    if ({branch_cnt, mispred_cnt} !== {exp_b, exp_m}) begin
      errors++;
      $display("FAIL beq_cnt got %0d/%0d want %0d/%0d", branch_cnt, mispred_cnt, exp_b, exp_m);
    end
  endtask

  task automatic test_jalr();
    dec_in(32'h30, 32'hDEAD_0000, '0, 32'd1, BR_NONE, 1'b1, JT_JALR, 1'b0, '0);
    forward_A_D = FWD_E; ALU_result_E = 32'h103; rs1_D = 32'hDEAD_0000;
    push_dec("jalr_fwd_e", 1'b1, 32'h41);
    #1;
    e = dec_q.pop_front(); checks++;
    if ({redirect_D, redirect_PC_D} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got redirect=%b pc=%h want %b %h", e.name, redirect_D, redirect_PC_D, e.flag, e.pc);
    end
    step(); exp_b++; exp_m++;
    // ctr=11 survives one not-taken decrement and keeps predicting taken.
    PC_F = 32'h30;
    dec_in(32'h30, 32'd1, 32'd2, 32'd4, BR_BEQ, 1'b0, 1'b0, 1'b1, 32'h41);
    push_dec("beq_after_jalr", 1'b1, 32'h31);
    #1;
    e = dec_q.pop_front(); checks++;
    if ({redirect_D, redirect_PC_D} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got redirect=%b pc=%h want %b %h", e.name, redirect_D, redirect_PC_D, e.flag, e.pc);
    end
    step(); exp_b++; exp_m++;
    push_fet("jalr_ctr11_fetch", 1'b1, 32'h41);
    #1;
    e = fet_q.pop_front(); checks++;
    if ({pred_taken_F, pred_target_F} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got taken=%b target=%h want %b %h", e.name, pred_taken_F, pred_target_F, e.flag, e.pc);
    end
  endtask

  task automatic test_signed_unsigned();
    dec_in(32'h40, 32'hFFFF_FFFF, 32'd1, 32'h10, BR_BLT, 1'b0, 1'b0, 1'b1, 32'h44);
    push_dec("blt_taken", 1'b0, 32'h44);
    #1;
    e = dec_q.pop_front(); checks++;
    if ({redirect_D, redirect_PC_D} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got redirect=%b pc=%h want %b %h", e.name, redirect_D, redirect_PC_D, e.flag, e.pc);
    end
    step(); exp_b++;
    dec_in(32'h40, 32'hFFFF_FFFF, 32'd1, 32'h10, BR_BLTU, 1'b0, 1'b0, 1'b1, 32'h44);
    push_dec("bltu_not_taken", 1'b1, 32'h41);
    #1;
    e = dec_q.pop_front(); checks++;
    if ({redirect_D, redirect_PC_D} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got redirect=%b pc=%h want %b %h", e.name, redirect_D, redirect_PC_D, e.flag, e.pc);
    end
    step(); exp_b++; exp_m++;
    PC_F = 32'h40;
    push_fet("bltu_fetch", 1'b0, 32'h41);
    #1;
    e = fet_q.pop_front(); checks++;
    if ({pred_taken_F, pred_target_F} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got taken=%b target=%h want %b %h", e.name, pred_taken_F, pred_target_F, e.flag, e.pc);
    end
  endtask

  task automatic test_stall();
    dec_in(32'h50, 32'd3, 32'd3, 32'd8, BR_BGE, 1'b0, 1'b0, 1'b0, '0);
    stall_D = 1'b1;
    push_dec("bge_stalled", 1'b0, 32'h52);
    #1;
    e = dec_q.pop_front(); checks++;
    if ({redirect_D, redirect_PC_D} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got redirect=%b pc=%h want %b %h", e.name, redirect_D, redirect_PC_D, e.flag, e.pc);
    end
    step();
    PC_F = 32'h50;
    push_fet("stall_no_update", 1'b0, 32'h51);
    #1;
    e = fet_q.pop_front(); checks++;
    if ({pred_taken_F, pred_target_F} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got taken=%b target=%h want %b %h", e.name, pred_taken_F, pred_target_F, e.flag, e.pc);
    end
    checks++;
    if ({branch_cnt, mispred_cnt} !== {exp_b, exp_m}) begin
      errors++;
      $display("FAIL stall_cnt got %0d/%0d want %0d/%0d", branch_cnt, mispred_cnt, exp_b, exp_m);
    end
    dec_in(32'h50, 32'd3, 32'd3, 32'd8, BR_BGE, 1'b0, 1'b0, 1'b0, '0);
    push_dec("bge_released", 1'b1, 32'h52);
    #1;
    e = dec_q.pop_front(); checks++;
    if ({redirect_D, redirect_PC_D} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got redirect=%b pc=%h want %b %h", e.name, redirect_D, redirect_PC_D, e.flag, e.pc);
    end
    step(); exp_b++; exp_m++;
    push_fet("bge_alloc_fetch", 1'b1, 32'h52);
    #1;
    e = fet_q.pop_front(); checks++;
    if ({pred_taken_F, pred_target_F} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got taken=%b target=%h want %b %h", e.name, pred_taken_F, pred_target_F, e.flag, e.pc);
    end
  endtask

  task automatic test_alias();
    dec_in(32'h05, '0, '0, 32'h20, BR_NONE, 1'b1, JT_JAL, 1'b0, '0);
    push_dec("jal_05", 1'b1, 32'h0D);
    #1;
    e = dec_q.pop_front(); checks++;
    if ({redirect_D, redirect_PC_D} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got redirect=%b pc=%h want %b %h", e.name, redirect_D, redirect_PC_D, e.flag, e.pc);
    end
    step(); exp_b++; exp_m++;
    dec_in(32'h15, 32'd7, 32'd7, 32'h40, BR_BNE, 1'b0, 1'b0, 1'b0, '0);
    push_dec("bne_15_nt", 1'b0, 32'h16);
    #1;
    e = dec_q.pop_front(); checks++;
    if ({redirect_D, redirect_PC_D} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got redirect=%b pc=%h want %b %h", e.name, redirect_D, redirect_PC_D, e.flag, e.pc);
    end
    step(); exp_b++;
    PC_F = 32'h05;
    push_fet("alias_owner_kept", 1'b1, 32'h0D);
    #1;
    e = fet_q.pop_front(); checks++;
    if ({pred_taken_F, pred_target_F} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got taken=%b target=%h want %b %h", e.name, pred_taken_F, pred_target_F, e.flag, e.pc);
    end
    PC_F = 32'h15;
    push_fet("alias_tag_miss", 1'b0, 32'h16);
    #1;
    e = fet_q.pop_front(); checks++;
    if ({pred_taken_F, pred_target_F} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got taken=%b target=%h want %b %h", e.name, pred_taken_F, pred_target_F, e.flag, e.pc);
    end
    // Non-control instruction that Fetch predicted taken.
    dec_in(32'h60, '0, '0, '0, BR_NONE, 1'b0, 1'b0, 1'b1, 32'h99);
    push_dec("stale_alias", 1'b1, 32'h61);
    #1;
    e = dec_q.pop_front(); checks++;
    if ({redirect_D, redirect_PC_D} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got redirect=%b pc=%h want %b %h", e.name, redirect_D, redirect_PC_D, e.flag, e.pc);
    end
    step(); exp_m++;
    PC_F = 32'hFFFF_FFFF;
    push_fet("fetch_pc_wrap", 1'b0, 32'h0);
    #1;
    e = fet_q.pop_front(); checks++;
    if ({pred_taken_F, pred_target_F} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got taken=%b target=%h want %b %h", e.name, pred_taken_F, pred_target_F, e.flag, e.pc);
    end
    checks++;
    if ({branch_cnt, mispred_cnt} !== {exp_b, exp_m}) begin
      errors++;
      $display("FAIL alias_cnt got %0d/%0d want %0d/%0d", branch_cnt, mispred_cnt, exp_b, exp_m);
    end
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0; exp_b = '0; exp_m = '0;
    PC_F = 32'h05;
    push_fet("midreset_fetch", 1'b0, 32'h06);
    #1;
    e = fet_q.pop_front(); checks++;
    if ({pred_taken_F, pred_target_F} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got taken=%b target=%h want %b %h", e.name, pred_taken_F, pred_target_F, e.flag, e.pc);
    end
    checks++;
    if ({branch_cnt, mispred_cnt} !== {exp_b, exp_m}) begin
      errors++;
      $display("FAIL midreset_cnt got %0d/%0d want %0d/%0d", branch_cnt, mispred_cnt, exp_b, exp_m);
    end
    rst_n = 1'b1;
    dec_in(32'h05, '0, '0, 32'h20, BR_NONE, 1'b1, JT_JAL, 1'b0, '0);
    step(); exp_b++; exp_m++;
    push_fet("post_reset_fetch", 1'b1, 32'h0D);
    #1;
    e = fet_q.pop_front(); checks++;
    if ({pred_taken_F, pred_target_F} !== {e.flag, e.pc}) begin
      errors++;
      $display("FAIL %s got taken=%b target=%h want %b %h", e.name, pred_taken_F, pred_target_F, e.flag, e.pc);
    end
    checks++;
    if ({branch_cnt, mispred_cnt} !== {exp_b, exp_m}) begin
      errors++;
      $display("FAIL post_reset_cnt got %0d/%0d want %0d/%0d", branch_cnt, mispred_cnt, exp_b, exp_m);
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_jalr();
    test_signed_unsigned();
    test_stall();
    test_alias();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpu_branch_predictor.md
# bpu_branch_predictor

Parametrised successor to the decode-stage branch/jump resolver. Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, read in Fetch and updated in Decode, plus misprediction detection and redirect. Sits between the Fetch PC mux (prediction) and the Decode stage (resolution, forwarding from E/M/W), and exports performance counters.

## Interface
Parameters:
- XLEN, 32, datapath and PC width
- ENTRIES, 16, BTB/counter entries (power of two, ≥2); IDX_W = log2(ENTRIES)
- TAG_W, 8, stored PC tag bits; IDX_W+TAG_W ≤ XLEN

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- PC_F  in  XLEN  fetch PC (word index)
- pred_taken_F  out  1  fetch prediction
- pred_target_F  out  XLEN  predicted next PC
- valid_D  in  1  Decode holds a real instruction
- stall_D  in  1  Decode held this cycle
- PC_D, rs1_D, rs2_D, imm_D  in  XLEN  decode operands; imm_D is a byte offset
- ALU_result_E, ALU_result_M, WB_data  in  XLEN  forwarding sources
- forward_A_D, forward_B_D  in  2  00 none, 01 E, 10 M, 11 W
- branch  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU, 010 none; others = none
- jump  in  1  JAL/JALR
- jump_type  in  1  1 JAL, 0 JALR
- pred_taken_D, pred_target_D  in  1/XLEN  Fetch prediction piped to Decode
- redirect_D  out  1  mispredict, flush and redirect
- redirect_PC_D  out  XLEN  correct next PC
- branch_cnt, mispred_cnt  out  32  resolved control-flow / mispredict counts

## Operation
- Word PC: off = imm_D >>> 2 (arithmetic). JAL/branch target = PC_D + off; JALR target = ((rs1f + imm_D) & ~1) >> 2 (logical). rs1f/rs2f selected per forward code.
- Resolution: taken = jump | branch condition (signed for BLT/BGE, unsigned for BLTU/BGEU). Jump has priority over branch.
- ctl = valid_D & (jump | branch is a real branch code).
- Mispredict: ctl & (taken ≠ pred_taken_D | (taken & target ≠ pred_target_D)); also non-ctl with pred_taken_D=1 (stale alias) → redirect to PC_D+1.
- redirect_D = mispredict & ~stall_D; redirect_PC_D = taken ? target : PC_D+1 (wrap mod 2^XLEN).
- Lookup: idx = PC_F[IDX_W-1:0], tag = PC_F[IDX_W+TAG_W-1:IDX_W]; hit = valid[idx] & tag match. pred_taken_F = hit & ctr[idx][1]; pred_target_F = pred_taken_F ? btb_target[idx] : PC_F+1.
- Update (ctl & ~stall_D), index/tag from PC_D:
  - jump: write tag/target, valid=1, ctr=11.
  - branch, hit: ctr +1 if taken, -1 if not, saturating 00..11; if taken, write target.
  - branch, miss, taken: allocate (tag, target, valid=1, ctr=10). Miss, not taken: no change.
- Counters: branch_cnt +1 per ctl & ~stall_D; mispred_cnt +1 per redirect_D; both saturate at 2^32-1.

## Timing
- Reset: all valid=0, all ctr=01, target/tag=0, counters=0. Outputs: pred_taken_F=0, pred_target_F=PC_F+1, redirect_D combinational from inputs.
- Lookup and resolution combinational (0 cycles); table/counter update on the rising edge after Decode resolves, visible to Fetch next cycle.
- Same-cycle read and write of one index: Fetch sees the old entry.
- stall_D=1: no update, no count, redirect_D=0; the held instruction resolves once on its first unstalled cycle.
- rst_n low mid-operation clears state immediately; first edge after release is normal.

## Structure
- Package bpu_pkg: branch codes, JAL/JALR, forward codes, CTR_RESET=2'b01, CTR_ALLOC=2'b10.
- Sub-module bpu_table: valid/tag/target/counter arrays, async read port (Fetch), sync write port (Decode update). Top holds forwarding, resolution, redirect, counters.

## Test plan
- Reset, PC_F=0x10 → pred_taken_F=0, pred_target_F=0x11; counters 0.
- BEQ at PC_D=0x20, imm=-8, rs1=rs2=5, pred 0 → redirect_D=1, redirect_PC_D=0x1E; next cycle PC_F=0x20 → pred_taken_F=1, target 0x1E.
- Same BEQ not taken twice → ctr 10→01, third lookup pred_taken_F=0; branch_cnt=3, mispred_cnt=2.
- JALR, forward_A_D=01, ALU_result_E=0x103, imm=1 → redirect_PC_D=0x41, entry ctr=11.
- BLT rs1=0xFFFFFFFF, rs2=1 taken; BLTU same not taken; stall_D=1 cycle → no update, redirect_D=0.
- Aliasing: PC 0x05 and 0x15 (ENTRIES=16) → tag miss, not-taken branch leaves entry unchanged.
